// File: rtl/input_debouncer.sv
// input_debouncer: per-bit switch/button conditioner.
// Each raw input is synchronized by two flops and accepted only after it has
// held a level different from the debounced output for STABLE_COUNT
// consecutive cycles. A level change shorter than that is discarded.
// Optional macro DEBOUNCE_EDGE_DETECT_EN builds registered rise/fall/changed
// pulses. Without it those outputs are tied to 0 and no edge registers exist.
module input_debouncer #(
  parameter int WIDTH        = 8,
  parameter int STABLE_COUNT = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // The counter only has to reach STABLE_COUNT-1, so it never wraps.
  localparam int            CW   = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_sw_out;
  logic [WIDTH-1:0] w_sw_next;

  // Two-flop synchronizer for the asynchronous pin levels.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments make r_sync2 take the previous r_sync1,
    // giving two real flop stages instead of one collapsed wire.
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
    end
  end

  // One independent stability counter per bit.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic [CW-1:0] r_cnt;
    logic          w_diff;
    logic          w_done;

    assign w_diff       = r_sync2[g] ^ r_sw_out[g];
    assign w_done       = w_diff && (r_cnt == LAST);
    assign w_sw_next[g] = w_done ? r_sync2[g] : r_sw_out[g];

    // Count cycles of disagreement; any agreement or an acceptance restarts.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_cnt <= '0;
      end else if (!w_diff || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Debounced output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sw_out <= '0;
    end else begin
      r_sw_out <= w_sw_next;
    end
  end

  assign sw_out = r_sw_out;

`ifdef DEBOUNCE_EDGE_DETECT_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;

  // Edge pulses registered alongside sw_out so they appear in the same cycle
  // as the new level; reset loads 0 and therefore never creates a pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_rise    <= w_sw_next & ~r_sw_out;
      r_fall    <= ~w_sw_next & r_sw_out;
      r_changed <= |(w_sw_next ^ r_sw_out);
    end
  end

  assign rise    = r_rise;
  assign fall    = r_fall;
  assign changed = r_changed;
`else
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: a STABLE_COUNT=4 instance driven from a vector
// table plus reset sequences, checked every cycle against a scoreboard of
// expected output events; and a STABLE_COUNT=1 instance checked against a
// three-edge delay of the applied stimulus.
module tb_input_debouncer;

  localparam int SC = 4;
`ifdef DEBOUNCE_EDGE_DETECT_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] sw;
    int         hold;
    logic [7:0] out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } vec_t;

  typedef struct {
    int         due;
    logic [7:0] out;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] sw_in;
  logic [7:0] sw_out, rise, fall;
  logic       changed;
  logic [7:0] sw_out1, rise1, fall1;
  logic       changed1;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  bit   chk_en   = 1'b0;
  exp_t sb[$];

  // Expected levels held by the checker between scoreboard events.
  logic [7:0] exp_sw   = '0;
  logic [7:0] prev_e1  = '0;
  logic [7:0] h_in0 = '0, h_in1 = '0, h_in2 = '0;
  bit         h_rst0 = 1'b1, h_rst1 = 1'b1, h_rst2 = 1'b1;

  input_debouncer #(.WIDTH(8), .STABLE_COUNT(SC)) u_dut (
    .clock(clock), .reset(reset), .sw_in(sw_in),
    .sw_out(sw_out), .rise(rise), .fall(fall), .changed(changed)
  );

  input_debouncer #(.WIDTH(8), .STABLE_COUNT(1)) u_dut1 (
    .clock(clock), .reset(reset), .sw_in(sw_in),
    .sw_out(sw_out1), .rise(rise1), .fall(fall1), .changed(changed1)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int due, input logic [7:0] out,
                          input logic [7:0] r, input logic [7:0] f);
    exp_t e;
    int   i;
    e.due  = due;
    e.out  = out;
    e.rise = EDGE_EN ? r : 8'h00;
    e.fall = EDGE_EN ? f : 8'h00;
    e.chg  = EDGE_EN ? ((r | f) != 8'h00) : 1'b0;
    i = 0;
    while (i < sb.size() && sb[i].due <= due) i++;
    sb.insert(i, e);
  endtask

  // Edge counter and stimulus history as seen at each rising edge.
  always @(posedge clock) begin
    cyc    <= cyc + 1;
    h_in2  <= h_in1;
    h_in1  <= h_in0;
    h_in0  <= sw_in;
    h_rst2 <= h_rst1;
    h_rst1 <= h_rst0;
    h_rst0 <= reset;
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clock) begin
    logic [7:0] er, ef, e1, er1, ef1;
    logic       ec;
    exp_t       e;
    if (chk_en) begin
      er = '0; ef = '0; ec = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        if (e.due < cyc) check("sb_late", 32'(e.due), 32'(cyc));
        exp_sw = e.out; er = e.rise; ef = e.fall; ec = e.chg;
      end
      check("sw_out", 32'(sw_out), 32'(exp_sw));
      check("pulses", {15'b0, changed, rise, fall}, {15'b0, ec, er, ef});

      e1  = (h_rst0 || h_rst1 || h_rst2) ? 8'h00 : h_in2;
      er1 = (EDGE_EN && !h_rst0) ? (e1 & ~prev_e1) : 8'h00;
      ef1 = (EDGE_EN && !h_rst0) ? (~e1 & prev_e1) : 8'h00;
      check("sc1_sw_out", 32'(sw_out1), 32'(e1));
      check("sc1_pulses", {15'b0, changed1, rise1, fall1},
            {15'b0, ((er1 | ef1) != 8'h00), er1, ef1});
      prev_e1 = e1;
    end
  end

  initial begin
    vec_t tbl[14];
    int   rel;

    tbl[0]  = '{8'h01, 3,  8'h00, 8'h00, 8'h00, 1'b0}; // short pulse ignored
    tbl[1]  = '{8'h00, 8,  8'h00, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{8'h05, 10, 8'h05, 8'h05, 8'h00, 1'b1}; // clean step
    tbl[3]  = '{8'hFF, 10, 8'hFF, 8'hFA, 8'h00, 1'b1};
    tbl[4]  = '{8'h7F, 3,  8'hFF, 8'h00, 8'h00, 1'b0}; // bit7 low 3 cycles
    tbl[5]  = '{8'hFF, 1,  8'hFF, 8'h00, 8'h00, 1'b0}; // glitch back high
    tbl[6]  = '{8'h7F, 10, 8'h7F, 8'h00, 8'h80, 1'b1}; // restarted run
    tbl[7]  = '{8'h0F, 10, 8'h0F, 8'h00, 8'h70, 1'b1};
    tbl[8]  = '{8'hF0, 10, 8'hF0, 8'hF0, 8'h0F, 1'b1}; // rise+fall together
    tbl[9]  = '{8'h00, 10, 8'h00, 8'h00, 8'hF0, 1'b1};
    tbl[10] = '{8'h81, 10, 8'h81, 8'h81, 8'h00, 1'b1};
    tbl[11] = '{8'h80, 2,  8'h81, 8'h00, 8'h00, 1'b0}; // bit0 glitch only
    tbl[12] = '{8'h81, 10, 8'h81, 8'h00, 8'h00, 1'b0};
    tbl[13] = '{8'h00, 10, 8'h00, 8'h00, 8'h81, 1'b1};

    reset = 1'b1;
    sw_in = 8'h00;
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    reset  = 1'b0;
    repeat (4) @(negedge clock);

    for (int i = 0; i < 14; i++) begin
      sw_in = tbl[i].sw;
      if ((tbl[i].rise | tbl[i].fall) != 8'h00)
        push_exp(cyc + SC + 2, tbl[i].out, tbl[i].rise, tbl[i].fall);
      repeat (tbl[i].hold) @(negedge clock);
    end

    // Reset lands on the third counting edge of a run: the partial count is
    // lost and the full latency restarts from the release.
    sw_in = 8'h01;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    rel   = cyc;
    push_exp(rel + SC + 2, 8'h01, 8'h01, 8'h00);
    repeat (10) @(negedge clock);

    // Reset with sw_out high clears it without a fall pulse; the held input
    // then rises again after the full latency.
    reset = 1'b1;
    push_exp(cyc + 1, 8'h00, 8'h00, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    rel   = cyc;
    push_exp(rel + SC + 2, 8'h01, 8'h01, 8'h00);
    repeat (10) @(negedge clock);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 Parameter WIDTH, default 8: number of independent switch/button inputs conditioned.
REQ-002 Parameter STABLE_COUNT, default 1000000: consecutive clock cycles a synchronized level must persist before it is accepted; legal range 1 to 2^24-1.
REQ-003 clock  input  1  system clock (100 MHz board clock); all state updates on its rising edge.
REQ-004 reset  input  1  one clock; reset is synchronous and active-high.
REQ-005 sw_in  input  WIDTH  raw asynchronous switch/button levels from the board pins.
REQ-006 sw_out  output  WIDTH  debounced levels; feeds the A/B switch inputs and reset of the display/math top.
REQ-007 rise  output  WIDTH  one-cycle pulse per bit when sw_out bit goes 0->1.
REQ-008 fall  output  WIDTH  one-cycle pulse per bit when sw_out bit goes 1->0.
REQ-009 changed  output  1  one-cycle pulse, OR of all rise and fall bits in the same cycle.

Function
REQ-010 Each bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-011 Each bit SHALL own an independent counter, ceil(log2(STABLE_COUNT+1)) bits wide, saturating never (cleared before overflow).
REQ-012 Per bit, on each edge: if sync2 == sw_out then counter <= 0; else if counter == STABLE_COUNT-1 then sw_out <= sync2 and counter <= 0; else counter <= counter+1.
REQ-013 Latency: after a clean step on sw_in first sampled at edge k, sw_out SHALL change after edge k+STABLE_COUNT+1 (STABLE_COUNT+2 edges inclusive), never earlier.
REQ-014 A glitch (sync2 returning to sw_out level) at any count SHALL clear that bit's counter; the next qualifying run restarts from 0.
REQ-015 A pulse shorter than STABLE_COUNT cycles at sync2 SHALL never alter sw_out, rise, fall or changed.
REQ-016 rise/fall bits SHALL be registered, asserted in exactly the cycle sw_out first shows the new value, deasserted the next cycle.
REQ-017 Simultaneous acceptance on several bits in one edge SHALL assert all corresponding rise/fall bits together and a single changed pulse.
REQ-018 With STABLE_COUNT = 1, sw_out SHALL follow sync2 with one cycle delay (latency 3 edges inclusive).
REQ-019 Bits SHALL be fully independent; activity on one bit never affects another bit's counter.

Reset
REQ-020 While reset is high at a rising edge: sync1, sync2, sw_out, all counters, rise, fall, changed SHALL load 0.
REQ-021 Reset asserted mid-count SHALL discard the partial count; no rise/fall pulse is generated by reset itself.
REQ-022 After reset deasserts with sw_in bits held high, those bits SHALL rise per REQ-013 and produce rise pulses.

Configuration
REQ-023 Macro DEBOUNCE_EDGE_DETECT_EN: when defined, rise, fall and changed SHALL behave per REQ-016/REQ-017.
REQ-024 When DEBOUNCE_EDGE_DETECT_EN is not defined, rise, fall and changed SHALL be constant 0, ports remain present, no edge registers are built; sw_out behaviour is unchanged.

Verification (STABLE_COUNT=4, WIDTH=8, macro defined unless stated)
REQ-025 Reset, then sw_in 0x00->0x05 at edge 10 and held -> sw_out = 0x05 after edge 15; rise = 0x05 and changed = 1 for exactly that one cycle.
REQ-026 sw_in bit0 high for 3 cycles then low -> sw_out stays 0x00, rise/fall/changed never assert.
REQ-027 sw_out = 0xFF, bit7 low for 3 cycles, high 1 cycle, low held -> counter restarts; sw_out = 0x7F 6 edges after final low sample, fall = 0x80.
REQ-028 sw_out = 0x0F, sw_in -> 0xF0 in one step -> single update cycle: sw_out = 0xF0, rise = 0xF0, fall = 0x0F, changed = 1.
REQ-029 sw_in = 0x01 held, reset pulsed at 3rd counting edge -> sw_out = 0x00 during reset, then 0x01 at 6th edge after reset release with one rise pulse.
REQ-030 Macro undefined, repeat REQ-025 -> sw_out timing identical; rise, fall, changed constant 0.
